// File: rtl/proc_control_unit.sv
// proc_control_unit: Moore control FSM for the simple processor datapath.
// Sequences PC, IR, data memory, register file and ALU from the opcode in IR,
// exports state codes for the HEX debug display and counts retired instructions.
// Optional build macro: PROC_CTRL_ILLEGAL_TRAP_EN (opcodes 0110-1111 trap to
// Halt and raise a sticky Illegal flag instead of executing as NOOP).
module proc_control_unit #(
    parameter int unsigned DADDR_W = 8,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [15:0]        IR,
    output logic               PC_clr,
    output logic               PC_up,
    output logic               IR_ld,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [RADDR_W-1:0] RF_W_addr,
    output logic               RF_W_en,
    output logic [RADDR_W-1:0] RF_Ra_addr,
    output logic [RADDR_W-1:0] RF_Rb_addr,
    output logic [2:0]         ALU_s0,
    output logic [3:0]         State,
    output logic [3:0]         NextState,
    output logic [CNT_W-1:0]   InstrCount,
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    output logic               Illegal,
`endif
    output logic               Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       retire;
    logic [3:0] opcode;

    assign opcode    = IR[15:12];
    assign State     = state;
    assign NextState = next_state;

    // Next-state selection and Moore outputs decoded from state and IR fields
    always_comb begin
        next_state = S_INIT;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = 3'b000;
        Halted     = 1'b0;
        retire     = 1'b0;
        case (state)
            S_INIT: begin
                PC_clr     = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                IR_ld      = 1'b1;
                PC_up      = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'b0000: next_state = S_NOOP;
                    4'b0001: next_state = S_STORE;
                    4'b0010: next_state = S_LOADA;
                    4'b0011: next_state = S_ADD;
                    4'b0100: next_state = S_SUB;
                    4'b0101: next_state = S_HALT;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                    default: next_state = S_HALT;
`else
                    default: next_state = S_NOOP;
`endif
                endcase
            end
            S_NOOP: begin
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            // LoadA presents the read address one cycle early to cover memory latency
            S_LOADA, S_LOADB: begin
                D_addr     = DADDR_W'(IR[11:4]);
                RF_s       = 1'b1;
                RF_W_addr  = RADDR_W'(IR[3:0]);
                RF_W_en    = (state == S_LOADB);
                retire     = (state == S_LOADB);
                next_state = (state == S_LOADA) ? S_LOADB : S_FETCH;
            end
            S_STORE: begin
                D_addr     = DADDR_W'(IR[7:0]);
                RF_Ra_addr = RADDR_W'(IR[11:8]);
                D_wr       = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = RADDR_W'(IR[11:8]);
                RF_Rb_addr = RADDR_W'(IR[7:4]);
                RF_W_addr  = RADDR_W'(IR[3:0]);
                ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
                RF_W_en    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                Halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_INIT;
        endcase
    end

    // State register and retired-instruction counter with synchronous reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= S_INIT;
            InstrCount <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
        end
    end

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, set on the Decode transition into Halt
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Illegal <= 1'b0;
        end else if (state == S_DECODE && opcode >= 4'b0110) begin
            Illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed scenarios plus randomized instruction
// streams checked against a behavioural model of the control sequence.
module tb_proc_control_unit;

    localparam int unsigned DADDR_W = 8;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MOD = 16;

    logic               Clock;
    logic               Reset;
    logic [15:0]        IR;
    logic               PC_clr;
    logic               PC_up;
    logic               IR_ld;
    logic [DADDR_W-1:0] D_addr;
    logic               D_wr;
    logic               RF_s;
    logic [RADDR_W-1:0] RF_W_addr;
    logic               RF_W_en;
    logic [RADDR_W-1:0] RF_Ra_addr;
    logic [RADDR_W-1:0] RF_Rb_addr;
    logic [2:0]         ALU_s0;
    logic [3:0]         State;
    logic [3:0]         NextState;
    logic [CNT_W-1:0]   InstrCount;
    logic               Halted;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic               Illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    proc_control_unit #(.DADDR_W(DADDR_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s0(ALU_s0), .State(State), .NextState(NextState),
        .InstrCount(InstrCount),
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        .Illegal(Illegal),
`endif
        .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Packed view of every combinational control output
    function automatic logic [37:0] obs();
        return {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState, Halted};
    endfunction

    // Model: which state an opcode leads to from Decode
    function automatic int op_target(input logic [15:0] ir);
        int tgt [16] = '{3, 6, 4, 7, 8, 9, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        int op = int'(ir[15:12]);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        if (op >= 6) return 9;
`endif
        return tgt[op];
    endfunction

    function automatic int model_next(input int st, input logic [15:0] ir);
        if (st == 0) return 1;
        if (st == 1) return 2;
        if (st == 2) return op_target(ir);
        if (st == 4) return 5;
        if (st == 9) return 9;
        return 1;
    endfunction

    function automatic bit retires(input int st);
        return st == 3 || st == 5 || st == 6 || st == 7 || st == 8;
    endfunction

    // Model: expected control outputs for a state and instruction
    function automatic logic [37:0] exp_out(input int st, input logic [15:0] ir);
        logic       pc_clr = 0, pc_up = 0, ir_ld = 0, d_wr = 0, rf_s = 0, w_en = 0, halted = 0;
        logic [7:0] d_addr = 0;
        logic [3:0] w_addr = 0, ra = 0, rb = 0;
        logic [2:0] alu = 0;
        if (st == 0) pc_clr = 1;
        if (st == 1) begin ir_ld = 1; pc_up = 1; end
        if (st == 4 || st == 5) begin
            d_addr = ir[11:4]; rf_s = 1; w_addr = ir[3:0]; w_en = (st == 5);
        end
        if (st == 6) begin d_addr = ir[7:0]; ra = ir[11:8]; d_wr = 1; end
        if (st == 7 || st == 8) begin
            ra = ir[11:8]; rb = ir[7:4]; w_addr = ir[3:0]; w_en = 1;
            alu = (st == 7) ? 3'd1 : 3'd2;
        end
        if (st == 9) halted = 1;
        return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en,
                ra, rb, alu, 4'(st), 4'(model_next(st, ir)), halted};
    endfunction

    task automatic test_reset();
        Reset = 1'b0; IR = 16'h0000;
        step(); step();
        n_checks++;
        if (State !== 4'd0 || PC_clr !== 1'b1 || InstrCount !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: state=%0d pc_clr=%b cnt=%0d required 0/1/0", State, PC_clr, InstrCount);
        end
        n_checks++;
        if (obs() !== exp_out(0, IR)) begin
            n_fail++; $display("FAIL reset_outputs: got %h required %h", obs(), exp_out(0, IR));
        end
        Reset = 1'b1;
        step();
        n_checks++;
        if (State !== 4'd1 || IR_ld !== 1'b1 || PC_up !== 1'b1 || PC_clr !== 1'b0) begin
            n_fail++; $display("FAIL reset_fetch: state=%0d ir_ld=%b pc_up=%b pc_clr=%b required 1/1/1/0", State, IR_ld, PC_up, PC_clr);
        end
        step();
        n_checks++;
        if (State !== 4'd2 || NextState !== 4'd3) begin
            n_fail++; $display("FAIL reset_decode: state=%0d next=%0d required 2/3", State, NextState);
        end
        step(); step();
        exp_count = 1;
        n_checks++;
        if (State !== 4'd1 || InstrCount !== 4'(exp_count)) begin
            n_fail++; $display("FAIL noop_retire: state=%0d cnt=%0d required 1/%0d", State, InstrCount, exp_count);
        end
    endtask

    task automatic test_load();
        IR = 16'h2A53;
        step();
        n_checks++;
        if (NextState !== 4'd4) begin
            n_fail++; $display("FAIL load_decode: next=%0d required 4", NextState);
        end
        step();
        n_checks++;
        if (State !== 4'd4 || D_addr !== 8'hA5 || RF_W_addr !== 4'd3 || RF_s !== 1'b1 || RF_W_en !== 1'b0) begin
            n_fail++; $display("FAIL load_a: state=%0d addr=%h w=%0d s=%b en=%b required 4/a5/3/1/0", State, D_addr, RF_W_addr, RF_s, RF_W_en);
        end
        step();
        n_checks++;
        if (State !== 4'd5 || D_addr !== 8'hA5 || RF_W_addr !== 4'd3 || RF_s !== 1'b1 || RF_W_en !== 1'b1) begin
            n_fail++; $display("FAIL load_b: state=%0d addr=%h w=%0d s=%b en=%b required 5/a5/3/1/1", State, D_addr, RF_W_addr, RF_s, RF_W_en);
        end
        step();
        exp_count = (exp_count + 1) % CNT_MOD;
        n_checks++;
        if (State !== 4'd1 || InstrCount !== 4'(exp_count)) begin
            n_fail++; $display("FAIL load_retire: state=%0d cnt=%0d required 1/%0d", State, InstrCount, exp_count);
        end
    endtask

    task automatic test_add_sub();
        logic [15:0] ops [2] = '{16'h3124, 16'h4124};
        for (int k = 0; k < 2; k++) begin
            IR = ops[k];
            step(); step();
            n_checks++;
            if (State !== 4'(7 + k) || RF_Ra_addr !== 4'd1 || RF_Rb_addr !== 4'd2 || RF_W_addr !== 4'd4
                || ALU_s0 !== 3'(1 + k) || RF_W_en !== 1'b1 || RF_s !== 1'b0 || D_wr !== 1'b0) begin
                n_fail++; $display("FAIL alu_op%0d: state=%0d ra=%0d rb=%0d w=%0d alu=%0d en=%b required %0d/1/2/4/%0d/1",
                                   k, State, RF_Ra_addr, RF_Rb_addr, RF_W_addr, ALU_s0, RF_W_en, 7 + k, 1 + k);
            end
            step();
            exp_count = (exp_count + 1) % CNT_MOD;
            n_checks++;
            if (State !== 4'd1 || InstrCount !== 4'(exp_count)) begin
                n_fail++; $display("FAIL alu_retire%0d: state=%0d cnt=%0d required 1/%0d", k, State, InstrCount, exp_count);
            end
        end
    endtask

    task automatic test_store();
        IR = 16'h1307;
        step(); step();
        n_checks++;
        if (State !== 4'd6 || D_wr !== 1'b1 || D_addr !== 8'h07 || RF_Ra_addr !== 4'd3 || RF_W_en !== 1'b0) begin
            n_fail++; $display("FAIL store: state=%0d wr=%b addr=%h ra=%0d en=%b required 6/1/07/3/0", State, D_wr, D_addr, RF_Ra_addr, RF_W_en);
        end
        step();
        exp_count = (exp_count + 1) % CNT_MOD;
        n_checks++;
        if (State !== 4'd1 || D_wr !== 1'b0 || InstrCount !== 4'(exp_count)) begin
            n_fail++; $display("FAIL store_one_cycle: state=%0d wr=%b cnt=%0d required 1/0/%0d", State, D_wr, InstrCount, exp_count);
        end
    endtask

    task automatic test_count_wrap();
        IR = 16'h0000;
        for (int k = 0; k < 18; k++) begin
            step(); step(); step();
            exp_count = (exp_count + 1) % CNT_MOD;
            n_checks++;
            if (State !== 4'd1 || InstrCount !== 4'(exp_count)) begin
                n_fail++; $display("FAIL count_wrap%0d: state=%0d cnt=%0d required 1/%0d", k, State, InstrCount, exp_count);
            end
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        IR = 16'h5000;
        step(); step();
        n_checks++;
        if (State !== 4'd9 || Halted !== 1'b1 || NextState !== 4'd9) begin
            n_fail++; $display("FAIL halt_enter: state=%0d halted=%b next=%0d required 9/1/9", State, Halted, NextState);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (State !== 4'd9 || InstrCount !== 4'(exp_count)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL halt_hold: %0d bad cycles, state=%0d cnt=%0d required 9/%0d", bad, State, InstrCount, exp_count);
        end
        Reset = 1'b0;
        step();
        exp_count = 0;
        n_checks++;
        if (State !== 4'd0 || Halted !== 1'b0 || InstrCount !== 4'd0) begin
            n_fail++; $display("FAIL halt_reset: state=%0d halted=%b cnt=%0d required 0/0/0", State, Halted, InstrCount);
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        IR = 16'hF000;
        step(); step();
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        n_checks++;
        if (State !== 4'd9 || Illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_trap: state=%0d illegal=%b required 9/1", State, Illegal);
        end
        Reset = 1'b0;
        step();
        exp_count = 0;
        n_checks++;
        if (State !== 4'd0 || Illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal_clear: state=%0d illegal=%b required 0/0", State, Illegal);
        end
        Reset = 1'b1;
        step();
`else
        n_checks++;
        if (State !== 4'd3) begin
            n_fail++; $display("FAIL illegal_noop: state=%0d required 3", State);
        end
        step();
        exp_count = (exp_count + 1) % CNT_MOD;
        n_checks++;
        if (State !== 4'd1 || InstrCount !== 4'(exp_count)) begin
            n_fail++; $display("FAIL illegal_retire: state=%0d cnt=%0d required 1/%0d", State, InstrCount, exp_count);
        end
`endif
    endtask

    task automatic test_reset_in_load();
        IR = 16'h2A53;
        step(); step();
        n_checks++;
        if (State !== 4'd4) begin
            n_fail++; $display("FAIL rst_load_setup: state=%0d required 4", State);
        end
        Reset = 1'b0;
        step();
        exp_count = 0;
        n_checks++;
        if (State !== 4'd0 || D_wr !== 1'b0 || RF_W_en !== 1'b0 || InstrCount !== 4'd0) begin
            n_fail++; $display("FAIL rst_load: state=%0d wr=%b en=%b cnt=%0d required 0/0/0/0", State, D_wr, RF_W_en, InstrCount);
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_random();
        int m_state = 1;
        int m_count = exp_count;
        int halt_cycles = 0;
        bit rst_now;
        bit m_ill = 0;
        for (int i = 0; i < 1500; i++) begin
            n_checks++;
            if (obs() !== exp_out(m_state, IR) || InstrCount !== 4'(m_count)) begin
                n_fail++; $display("FAIL random_cycle%0d: outputs=%h cnt=%0d required %h/%0d (ir=%h)",
                                   i, obs(), InstrCount, exp_out(m_state, IR), m_count, IR);
            end
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            n_checks++;
            if (Illegal !== m_ill) begin
                n_fail++; $display("FAIL random_illegal%0d: got %b required %b", i, Illegal, m_ill);
            end
`endif
            rst_now = (halt_cycles >= 3) || ($urandom_range(0, 99) == 0);
            Reset = !rst_now;
            if (m_state == 1) begin
                IR = 16'($urandom);
                if (IR[15:12] == 4'd5 && $urandom_range(0, 3) != 0) IR[15:12] = 4'd3;
            end
            if (rst_now) begin
                m_state = 0; m_count = 0; m_ill = 0;
            end else begin
                if (retires(m_state)) m_count = (m_count + 1) % CNT_MOD;
                if (m_state == 2 && IR[15:12] >= 4'd6 && op_target(IR) == 9) m_ill = 1;
                m_state = model_next(m_state, IR);
            end
            halt_cycles = (m_state == 9) ? halt_cycles + 1 : 0;
            step();
        end
        Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_store();
        test_count_wrap();
        test_halt();
        test_illegal();
        test_reset_in_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
